md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 36 +++
 rtl/md_calc.sv | 74 +++++++
 rtl/md_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg -- shared definitions for the multiply/divide unit.
//   MDOp encodings, default latencies, FSM state encoding and a helper
//   that classifies multi-cycle operations.
// Configuration: MD_UNIT_DIV_EN enables div/divu; without it they decode
//   as reserved codes.
package md_unit_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // 3'b110 and 3'b111 are reserved (no-op).
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Operations that occupy the unit for a counted number of cycles.
    function automatic logic is_long_op(input logic [2:0] op);
`ifdef MD_UNIT_DIV_EN
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc -- combinational 64-bit {HI,LO} result for mult/multu/div/divu.
// Ports:
//   i_op       operation code (latched copy of MDOp)
//   i_a, i_b   latched operands
//   o_result   {HI,LO}: product, or {remainder, quotient} for division
//   o_div_zero high for div/divu with a zero divisor (result must be dropped)
// Configuration: MD_UNIT_DIV_EN includes the divider; otherwise only the
//   multiplier is built and div/divu produce zero.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_a_zx;
    logic [63:0] w_b_zx;

    assign w_a_sx = {{32{i_a[31]}}, i_a};
    assign w_b_sx = {{32{i_b[31]}}, i_b};
    assign w_a_zx = {32'd0, i_a};
    assign w_b_zx = {32'd0, i_b};

`ifdef MD_UNIT_DIV_EN
    logic        w_b_zero;
    logic [31:0] w_b_nz;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_qmag;
    logic [31:0] w_rmag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;

    assign w_b_zero = (i_b == '0);
    // Substitute a divisor of 1 so the divider never sees zero.
    assign w_b_nz   = w_b_zero ? 32'd1 : i_b;

    // Signed division on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally,
    // since negating the magnitude 0x80000000 yields 0x80000000 again.
    assign w_abs_a = i_a[31]  ? (~i_a + 32'd1)    : i_a;
    assign w_abs_b = w_b_nz[31] ? (~w_b_nz + 32'd1) : w_b_nz;
    assign w_qmag  = w_abs_a / w_abs_b;
    assign w_rmag  = w_abs_a % w_abs_b;
    assign w_q_s   = (i_a[31] ^ w_b_nz[31]) ? (~w_qmag + 32'd1) : w_qmag;
    assign w_r_s   = i_a[31] ? (~w_rmag + 32'd1) : w_rmag;
`endif

    always_comb begin
        o_result   = '0;
        o_div_zero = 1'b0;
        case (i_op)
            MD_MULT:  o_result = w_a_sx * w_b_sx;
            MD_MULTU: o_result = w_a_zx * w_b_zx;
`ifdef MD_UNIT_DIV_EN
            MD_DIV: begin
                o_result   = {w_r_s, w_q_s};
                o_div_zero = w_b_zero;
            end
            MD_DIVU: begin
                o_result   = {i_a % w_b_nz, i_a / w_b_nz};
                o_div_zero = w_b_zero;
            end
`endif
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   Start        request, accepted only while Busy is low
//   MDOp         000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   A, B         operands (rs / rt read data)
//   Busy         registered, high while a multi-cycle operation runs
//   HI, LO       registered result registers
// Parameters: MULT_CYCLES, DIV_CYCLES -- Busy duration per operation class.
// Configuration: MD_UNIT_DIV_EN enables div/divu; otherwise they are no-ops.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          r_state;
    md_state_e          w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_accept;
    logic               w_start_run;
    logic               w_done;
    logic [CNT_W-1:0]   w_run_len;
    logic [63:0]        w_result;
    logic               w_div_zero;
    logic               w_hi_we;
    logic               w_lo_we;
    logic [31:0]        w_hi_d;
    logic [31:0]        w_lo_d;

    assign w_accept    = Start && (r_state == ST_IDLE);
    assign w_start_run = w_accept && is_long_op(MDOp);
    assign w_done      = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
    assign w_run_len   = ((MDOp == MD_DIV) || (MDOp == MD_DIVU)) ?
                         CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_calc u_calc (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start_run) w_next_state = ST_RUN;
            ST_RUN:  if (w_done)      w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: HI/LO write enables and data
    always_comb begin
        w_hi_we = 1'b0;
        w_lo_we = 1'b0;
        w_hi_d  = w_result[63:32];
        w_lo_d  = w_result[31:0];
        if (w_done && !w_div_zero) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
        end else if (w_accept && (MDOp == MD_MTHI)) begin
            w_hi_we = 1'b1;
            w_hi_d  = A;
        end else if (w_accept && (MDOp == MD_MTLO)) begin
            w_lo_we = 1'b1;
            w_lo_d  = A;
        end
    end

    // Counter, operand latches, Busy and HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_busy <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_busy <= (w_next_state == ST_RUN);
            if (w_start_run) begin
                r_cnt <= w_run_len;
                r_op  <= MDOp;
                r_a   <= A;
                r_b   <= B;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_hi_we) r_hi <= w_hi_d;
            if (w_lo_we) r_lo <= w_lo_d;
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
